// File: rtl/uart_pkg.sv
// Shared UART constants and the byte type used across the receive/transmit path.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO from uart_rx to uart_tx. Latency: 1 cycle write-to-read (first-word fall-through).
// Backpressure: rd_ready stalls the read side; writes never stall, writes into a full FIFO are dropped and flagged.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = UART_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic              pop;
    logic              push;
    logic              drop;

    // Status is decoded from the registered count only, so no input reaches an output combinationally.
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign rd_valid = !empty;
    assign rd_data  = mem[rp];

    // A pop frees the slot in the same cycle, so a full FIFO can still accept a write alongside it.
    assign pop  = rd_valid && rd_ready;
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // Setting wins over clearing so a drop is never lost.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wp] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo: queue-based reference model checked every cycle, plus literal checks.
module tb_uart_byte_fifo;

    localparam int DW = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready = 1'b0;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_byte_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored bytes and a sticky flag, updated from the inputs at each edge.
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            started = 1'b0;

    always @(posedge clk) begin
        bit was_full;
        bit can_pop;
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            started = 1'b1;
        end else begin
            was_full = (q.size() == DP);
            can_pop  = (q.size() > 0) && rd_ready;
            if (can_pop) void'(q.pop_front());
            if (wr_en && (!was_full || can_pop)) q.push_back(wr_data);
            if (wr_en && was_full && !can_pop) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_count",    32'(count),    32'(q.size()));
            chk("m_empty",    32'(empty),    32'(q.size() == 0));
            chk("m_full",     32'(full),     32'(q.size() == DP));
            chk("m_rd_valid", 32'(rd_valid), 32'(q.size() != 0));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            if (q.size() != 0) chk("m_rd_data", 32'(rd_data), 32'(q[0]));
        end
    end

    // Apply one cycle of inputs, let the edge consume them, then return to idle just after the edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en        = w;
        wr_data      = d;
        rd_ready     = r;
        clr_overflow = c;
        @(posedge clk);
        #1;
        wr_en        = 1'b0;
        wr_data      = '0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Single byte with the reader stalled, then one pop.
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("one_valid", 32'(rd_valid), 32'd1);
        chk("one_data",  32'(rd_data),  32'h55);
        chk("one_count", 32'(count),    32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("one_empty", 32'(empty), 32'd1);

        // Fill across the pointer wrap, then one dropped write.
        for (int i = 0; i < DP; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full",  32'(full),     32'd1);
        chk("fill_count", 32'(count),    32'd16);
        chk("fill_ovf",   32'(overflow), 32'd0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("drop_ovf",   32'(overflow), 32'd1);
        chk("drop_count", 32'(count),    32'd16);
        for (int i = 0; i < DP; i++) begin
            chk("drain_data", 32'(rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Full with simultaneous write and pop.
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DP; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("fullrw_count", 32'(count),    32'd16);
        chk("fullrw_ovf",   32'(overflow), 32'd0);
        chk("fullrw_head",  32'(rd_data),  32'h11);
        for (int i = 0; i < DP - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw_last", 32'(rd_data), 32'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw_empty", 32'(empty), 32'd1);

        // Empty with simultaneous write and read request: push only.
        cyc(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("emptyrw_count", 32'(count),    32'd1);
        chk("emptyrw_data",  32'(rd_data),  32'h3C);
        chk("emptyrw_valid", 32'(rd_valid), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Drop together with clear: set wins; clear alone then works.
        for (int i = 0; i < DP; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("setclr_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr2_ovf", 32'(overflow), 32'd0);

        // Leave 5 entries, then reset with a write in the reset cycle.
        for (int i = 0; i < DP - 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("five_count", 32'(count),   32'd5);
        chk("five_head",  32'(rd_data), 32'h2B);
        rst = 1'b1;
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst_count", 32'(count),    32'd0);
        chk("midrst_empty", 32'(empty),    32'd1);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
